// File: rtl/frequency_generator_if.sv
// Avalon-MM control slave bundle for the frequency generator.
// Latency: n/a (wires only); readdata is registered inside the slave.
// Backpressure: none, the slave accepts every read/write in one clock.
// Ports: address[3:0], write, writedata[7:0], read, readdata[7:0].
`timescale 1ns/1ps
interface frequency_generator_if;
  logic [3:0] address;
  logic       write;
  logic [7:0] writedata;
  logic       read;
  logic [7:0] readdata;

  modport master (
    output address, write, writedata, read,
    input  readdata
  );

  modport slave (
    input  address, write, writedata, read,
    output readdata
  );
endinterface

// File: rtl/frequency_generator.sv
// Programmable NCO square-wave source (free-run or N-cycle burst) on an 8-bit Avalon-MM slave.
// Latency: register reads 1 clock; output lags acc[31] by 1 clock, first accumulate 1 clock after enable.
// Backpressure: none; every bus access completes in one clock, no wait states.
// Ports: csi_MCLK_clk (clock), rsi_MRST_reset (async active-high), avs_ctrl (slave modport), frequent_out.
`timescale 1ns/1ps
module frequency_generator (
  input  logic                 csi_MCLK_clk,
  input  logic                 rsi_MRST_reset,
  frequency_generator_if.slave avs_ctrl,
  output logic                 frequent_out
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_LAST, S_DONE} state_t;

  state_t      state, state_nxt;
  logic        enable_q, burst_q;
  logic        load_pending, done_q;
  logic [31:0] inc_shadow, active_inc;
  logic [15:0] burst_len, burst_tgt, edge_cnt;
  logic [31:0] acc, acc_sum;
  logic [31:0] cycles, snapshot;

  // Control decode. The FSM reacts to the CTRL write on the same edge it is
  // sampled, so next-state logic looks at the incoming value, not the register.
  logic ctrl_wr, en_nxt, burst_nxt, load_stb, clear_stb, inc_wr;
  logic running, keep_run, rise_raw, fall_raw, rise_eff;

  assign ctrl_wr   = avs_ctrl.write && (avs_ctrl.address == 4'd0);
  assign en_nxt    = ctrl_wr ? avs_ctrl.writedata[0] : enable_q;
  assign burst_nxt = ctrl_wr ? avs_ctrl.writedata[1] : burst_q;
  assign load_stb  = ctrl_wr && avs_ctrl.writedata[2];
  assign clear_stb = ctrl_wr && avs_ctrl.writedata[3];
  assign inc_wr    = avs_ctrl.write && (avs_ctrl.address >= 4'd2) && (avs_ctrl.address <= 4'd5);

  assign running  = (state == S_RUN) || (state == S_LAST);
  assign acc_sum  = acc + active_inc;
  assign rise_raw = !acc[31] && acc_sum[31];
  assign fall_raw = acc[31] && !acc_sum[31];
  // The accumulator only advances if we stay in RUN/LAST after this edge;
  // an edge that would land on a disable or a burst end is never counted.
  assign keep_run = running && ((state_nxt == S_RUN) || (state_nxt == S_LAST));
  assign rise_eff = keep_run && rise_raw;

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) state <= S_IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (en_nxt) begin
          if (!burst_nxt || (burst_len != 16'd0)) state_nxt = S_RUN;
          else                                    state_nxt = S_DONE;
        end
      end
      S_RUN: begin
        if (burst_q && rise_raw && ((edge_cnt + 16'd1) == burst_tgt)) state_nxt = S_LAST;
      end
      S_LAST: begin
        // Let the final high phase complete before stopping.
        if (fall_raw) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
    if (!en_nxt) state_nxt = S_IDLE;
  end

  // NCO datapath, edge counters and done flag.
  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      acc          <= '0;
      frequent_out <= 1'b0;
      cycles       <= '0;
      edge_cnt     <= '0;
      burst_tgt    <= '0;
      done_q       <= 1'b0;
    end else begin
      acc          <= keep_run ? acc_sum : 32'd0;
      // Gated by the current state so the last burst pulse keeps its full width.
      frequent_out <= (running && en_nxt) ? acc[31] : 1'b0;

      if (clear_stb)     cycles <= '0;
      else if (rise_eff) cycles <= cycles + 32'd1;

      // Burst length is latched at start so BURST writes mid-burst do nothing.
      if ((state == S_IDLE) && (state_nxt == S_RUN)) begin
        edge_cnt  <= '0;
        burst_tgt <= burst_len;
      end else if ((state == S_RUN) && rise_eff) begin
        edge_cnt  <= edge_cnt + 16'd1;
      end

      if (clear_stb || (state_nxt == S_IDLE))           done_q <= 1'b0;
      else if ((state_nxt == S_DONE) && (state != S_DONE)) done_q <= 1'b1;
    end
  end

  // Host-writable registers.
  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      enable_q     <= 1'b0;
      burst_q      <= 1'b0;
      load_pending <= 1'b0;
      inc_shadow   <= '0;
      active_inc   <= '0;
      burst_len    <= '0;
    end else begin
      if (ctrl_wr) begin
        enable_q <= avs_ctrl.writedata[0];
        burst_q  <= avs_ctrl.writedata[1];
      end
      // Only active_inc changes on load; acc keeps its phase.
      if (load_stb) begin
        active_inc   <= inc_shadow;
        load_pending <= 1'b0;
      end else if (inc_wr) begin
        load_pending <= 1'b1;
      end
      if (avs_ctrl.write) begin
        case (avs_ctrl.address)
          4'd2:    inc_shadow[7:0]   <= avs_ctrl.writedata;
          4'd3:    inc_shadow[15:8]  <= avs_ctrl.writedata;
          4'd4:    inc_shadow[23:16] <= avs_ctrl.writedata;
          4'd5:    inc_shadow[31:24] <= avs_ctrl.writedata;
          4'd6:    burst_len[7:0]    <= avs_ctrl.writedata;
          4'd7:    burst_len[15:8]   <= avs_ctrl.writedata;
          default: ;
        endcase
      end
    end
  end

  // Registered read port. Address 8 freezes the whole counter so bytes 9..11
  // read later belong to the same sample.
  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      avs_ctrl.readdata <= '0;
      snapshot          <= '0;
    end else if (avs_ctrl.read) begin
      case (avs_ctrl.address)
        4'd0:  avs_ctrl.readdata <= {6'b0, burst_q, enable_q};
        4'd1:  avs_ctrl.readdata <= {5'b0, load_pending, done_q, running};
        4'd2:  avs_ctrl.readdata <= inc_shadow[7:0];
        4'd3:  avs_ctrl.readdata <= inc_shadow[15:8];
        4'd4:  avs_ctrl.readdata <= inc_shadow[23:16];
        4'd5:  avs_ctrl.readdata <= inc_shadow[31:24];
        4'd6:  avs_ctrl.readdata <= burst_len[7:0];
        4'd7:  avs_ctrl.readdata <= burst_len[15:8];
        4'd8: begin
          snapshot          <= cycles;
          avs_ctrl.readdata <= cycles[7:0];
        end
        4'd9:    avs_ctrl.readdata <= snapshot[15:8];
        4'd10:   avs_ctrl.readdata <= snapshot[23:16];
        4'd11:   avs_ctrl.readdata <= snapshot[31:24];
        default: avs_ctrl.readdata <= 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_frequency_generator.sv
// Directed bench for frequency_generator: register map, free run, burst, retune, coherent read.
// Latency: inputs driven on the falling edge, outputs sampled 1 ns after the rising edge.
// Backpressure: none expected from the slave.
`timescale 1ns/1ps
module tb_frequency_generator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fout;
  int   vectors = 0;
  int   errs    = 0;
  logic [7:0] d;

  frequency_generator_if bus ();

  frequency_generator dut (
    .csi_MCLK_clk   (clk),
    .rsi_MRST_reset (rst),
    .avs_ctrl       (bus),
    .frequent_out   (fout)
  );

  always #5 clk = ~clk;

  // Output run-length monitor: every complete high/low run seen since the
  // last reset of the stats updates min/max; rising transitions are counted.
  int   m_min = 1000, m_max = 0, m_pulses = 0, m_run = 0;
  bit   m_seen = 1'b0;
  logic m_prev = 1'b0;

  always @(negedge clk) begin
    if (fout !== m_prev) begin
      if (m_seen) begin
        if (m_run < m_min) m_min = m_run;
        if (m_run > m_max) m_max = m_run;
      end
      if (fout === 1'b1) m_pulses++;
      m_seen = 1'b1;
      m_run  = 1;
      m_prev = fout;
    end else begin
      m_run++;
    end
  end

  task automatic mon_reset(input bit keep_run);
    m_min    = 1000;
    m_max    = 0;
    m_pulses = 0;
    if (!keep_run) m_seen = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] v);
    @(negedge clk);
    bus.address = a; bus.writedata = v; bus.write = 1'b1;
    @(posedge clk); #1;
    bus.write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] v);
    @(negedge clk);
    bus.address = a; bus.read = 1'b1;
    @(posedge clk); #1;
    bus.read = 1'b0;
    v = bus.readdata;
  endtask

  initial begin
    bus.address = '0; bus.write = 1'b0; bus.writedata = '0; bus.read = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_readdata", {24'b0, bus.readdata}, 32'h00);
    chk("rst_out", {31'b0, fout}, 32'h0);
    @(negedge clk); rst = 1'b0;
    rd(4'd0, d);  chk("rst_ctrl", {24'b0, d}, 32'h00);
    rd(4'd1, d);  chk("rst_status", {24'b0, d}, 32'h00);

    // Shadow INC writes, load_pending, ignored addresses, read hold
    wr(4'd2, 8'h00); wr(4'd3, 8'h00); wr(4'd4, 8'h00); wr(4'd5, 8'h40);
    rd(4'd1, d);  chk("status_pending", {24'b0, d}, 32'h04);
    rd(4'd5, d);  chk("inc_byte3", {24'b0, d}, 32'h40);
    repeat (2) @(posedge clk);
    #1;
    chk("readdata_hold", {24'b0, bus.readdata}, 32'h40);
    wr(4'd1, 8'hFF);
    rd(4'd1, d);  chk("status_wr_ignored", {24'b0, d}, 32'h04);
    wr(4'd12, 8'hAA);
    rd(4'd12, d); chk("addr12_zero", {24'b0, d}, 32'h00);

    // Load with enable=0: increment taken, output stays low
    mon_reset(1'b0);
    wr(4'd0, 8'h04);
    rd(4'd1, d);  chk("load_clears_pending", {24'b0, d}, 32'h00);
    repeat (10) @(posedge clk);
    #1;
    chk("load_idle_pulses", m_pulses, 32'd0);

    // Free run, INC=0x40000000: period 4, 2 high / 2 low, ~25 edges per 100 clocks
    mon_reset(1'b0);
    wr(4'd0, 8'h05);
    repeat (100) @(posedge clk);
    rd(4'd8, d);  chk("free_cycles_25", {31'b0, (d >= 8'd24 && d <= 8'd26)}, 32'd1);
    chk("free_min_run", m_min, 32'd2);
    chk("free_max_run", m_max, 32'd2);
    rd(4'd0, d);  chk("free_ctrl", {24'b0, d}, 32'h01);
    rd(4'd1, d);  chk("free_status", {24'b0, d}, 32'h01);

    // Asynchronous reset in the middle of a run, caught while the output is high
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fout === 1'b1) break;
    end
    chk("pre_reset_out_high", {31'b0, fout}, 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("reset_out", {31'b0, fout}, 32'h0);
    chk("reset_readdata", {24'b0, bus.readdata}, 32'h00);
    @(negedge clk); rst = 1'b0;
    rd(4'd1, d);  chk("reset_status", {24'b0, d}, 32'h00);
    rd(4'd8, d);  chk("reset_cycles", {24'b0, d}, 32'h00);
    rd(4'd0, d);  chk("reset_ctrl", {24'b0, d}, 32'h00);

    // Burst of 3 at INC=0x20000000: three 4-clock pulses, then done
    wr(4'd5, 8'h20); wr(4'd6, 8'h03); wr(4'd7, 8'h00);
    mon_reset(1'b0);
    wr(4'd0, 8'h07);
    repeat (60) @(posedge clk);
    #1;
    chk("burst_pulses", m_pulses, 32'd3);
    chk("burst_min_run", m_min, 32'd4);
    chk("burst_max_run", m_max, 32'd4);
    chk("burst_out_low", {31'b0, fout}, 32'h0);
    rd(4'd1, d);  chk("burst_status", {24'b0, d}, 32'h02);
    rd(4'd8, d);  chk("burst_cycles_b0", {24'b0, d}, 32'h03);
    rd(4'd9, d);  chk("burst_cycles_b1", {24'b0, d}, 32'h00);
    rd(4'd6, d);  chk("burst_len_rd", {24'b0, d}, 32'h03);

    // BURST=0: straight to DONE, no edges
    wr(4'd0, 8'h00);
    wr(4'd6, 8'h00);
    mon_reset(1'b0);
    wr(4'd0, 8'h07);
    rd(4'd1, d);  chk("burst0_status", {24'b0, d}, 32'h02);
    repeat (10) @(posedge clk);
    #1;
    chk("burst0_pulses", m_pulses, 32'd0);
    rd(4'd8, d);  chk("burst0_cycles", {24'b0, d}, 32'h03);

    // Clear strobe
    wr(4'd0, 8'h08);
    rd(4'd1, d);  chk("clear_status", {24'b0, d}, 32'h00);
    rd(4'd8, d);  chk("clear_cycles", {24'b0, d}, 32'h00);

    // Phase-continuous retune 16 -> 8 clock period
    wr(4'd5, 8'h10);
    wr(4'd0, 8'h05);
    mon_reset(1'b0);
    repeat (50) @(posedge clk);
    #1;
    chk("retune_old_min", m_min, 32'd8);
    chk("retune_old_max", m_max, 32'd8);
    wr(4'd5, 8'h20);
    rd(4'd1, d);  chk("retune_pending", {24'b0, d}, 32'h05);
    mon_reset(1'b1);
    wr(4'd0, 8'h05);
    rd(4'd1, d);  chk("retune_loaded", {24'b0, d}, 32'h01);
    repeat (40) @(posedge clk);
    #1;
    chk("retune_switch_min", {31'b0, (m_min >= 4)}, 32'd1);
    chk("retune_switch_max", {31'b0, (m_max <= 8)}, 32'd1);
    mon_reset(1'b0);
    repeat (30) @(posedge clk);
    #1;
    chk("retune_new_min", m_min, 32'd4);
    chk("retune_new_max", m_max, 32'd4);

    // Coherent multi-byte CYCLES read at 0x000000FF
    wr(4'd0, 8'h08);
    wr(4'd5, 8'h80); wr(4'd6, 8'hFF); wr(4'd7, 8'h00);
    wr(4'd0, 8'h07);
    repeat (600) @(posedge clk);
    rd(4'd1, d);  chk("coh_done", {24'b0, d}, 32'h02);
    rd(4'd8, d);  chk("coh_b0", {24'b0, d}, 32'hFF);
    wr(4'd0, 8'h00);
    wr(4'd0, 8'h01);
    repeat (6) @(posedge clk);
    rd(4'd9, d);  chk("coh_b1", {24'b0, d}, 32'h00);
    rd(4'd10, d); chk("coh_b2", {24'b0, d}, 32'h00);
    rd(4'd11, d); chk("coh_b3", {24'b0, d}, 32'h00);
    rd(4'd8, d);  chk("coh_resnap_b0", {31'b0, (d != 8'hFF)}, 32'd1);
    rd(4'd9, d);  chk("coh_resnap_b1", {24'b0, d}, 32'h01);
    wr(4'd0, 8'h08);
    rd(4'd8, d);  chk("coh_clear", {24'b0, d}, 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/frequency_generator.md
# frequency_generator

Programmable square-wave source on the Qsys Avalon-MM bus, complementary to the frequency-measurement peripheral: it drives a test/reference frequency onto a pin that the measurement block or external hardware can count. A 32-bit phase accumulator (NCO) produces a phase-continuous square wave, either free-running or as a burst of N cycles. All control and status goes through the 8-bit, 4-bit-address slave port.

## Interface
Parameters: none.
- csi_MCLK_clk  input  1  system clock; all logic on rising edge
- rsi_MRST_reset  input  1  asynchronous, active-high reset
- avs_ctrl_address  input  4  register select
- avs_ctrl_write  input  1  write strobe
- avs_ctrl_writedata  input  8  write data
- avs_ctrl_read  input  1  read strobe
- avs_ctrl_readdata  output  8  registered read data
- frequent_out  output  1  generated square wave, registered

## Operation
- Register map (W/R):
  - 0 CTRL. W: bit0 enable, bit1 burst mode, bit2 load (self-clearing strobe), bit3 clear (strobe). R: {6'b0, burst, enable}.
  - 1 STATUS. R: {5'b0, load_pending, done, running}. Writes ignored.
  - 2..5 INC shadow byte 0..3 (LSB first). W/R shadow.
  - 6..7 BURST count byte 0..1, 16-bit. W/R.
  - 8..11 CYCLES, 32-bit output-rising-edge count. Read of address 8 snapshots the full counter into a 32-bit holding register. Reads of 8..11 return the snapshot bytes, so a multi-byte read 8→11 is coherent.
  - 12..15: reads return 0; writes are ignored.
- Writing INC bytes sets load_pending. A load strobe copies shadow→active_inc and clears load_pending. The accumulator is not reset, so the output stays phase-continuous.
- Accumulator: acc <= acc + active_inc, mod 2^32, every clock while in RUN or LAST. frequent_out <= acc[31].
- A rising edge is acc[31] going 0→1. On each rising edge, CYCLES increments and wraps at 2^32.
- FSM states:
  - IDLE: acc=0, out=0.
    - enable=1 and burst=0 → RUN.
    - enable=1, burst=1, BURST≠0 → RUN.
    - enable=1, burst=1, BURST=0 → DONE immediately.
  - RUN: while burst=1, a rising edge that brings the burst edge count to BURST → LAST.
  - LAST: when acc[31] next falls (1→0), go to DONE and clear acc.
  - DONE: out=0, done=1. enable written 0 → IDLE.
  - Any state with enable written 0 → IDLE next clock; acc cleared, out 0.
- Burst edge counter (16-bit) clears on entry to RUN from IDLE.
- clear strobe: CYCLES=0 and done=0, next clock. If clear and a rising edge coincide, clear wins.
- running = state is RUN or LAST.
- Reset values: all registers, acc, active_inc, CYCLES, snapshot and state = 0/IDLE; avs_ctrl_readdata=0; frequent_out=0.

## Timing
- Write is sampled on the clock edge where avs_ctrl_write=1; the new value is visible from the following edge.
- Read latency is 1 clock. readdata updates on the edge where avs_ctrl_read=1 and holds otherwise.
- Enable write at edge T: state=RUN after T, first accumulate at T+1. frequent_out lags acc[31] by 1 clock.
- Output period = 2^32/active_inc clocks; duty 50% when active_inc is a power of two.
- active_inc=0 in RUN: out holds its current level, no edges.
- load with enable=0: active_inc updates, output stays 0.
- Simultaneous load and enable in one write: the new increment is used from the first accumulate.
- Writing BURST while running has no effect on the current burst.
- Async reset mid-burst: immediate IDLE, out=0, done=0.

## Test plan
- Reset: assert reset mid-RUN → frequent_out=0, STATUS=0x00, CYCLES=0, readdata=0.
- Free run: INC=0x40000000, CTRL=0x05 → out period 4 clocks (2 high/2 low); after 100 clocks CYCLES = 25 ±1.
- Burst: INC=0x20000000, BURST=3, CTRL=0x07 → exactly 3 high pulses of 4 clocks; then STATUS=0x02, out=0, CYCLES=3.
- BURST=0, CTRL=0x07 → DONE next clock, no edges, STATUS=0x02.
- Phase-continuous retune: running at INC=0x10000000, write INC=0x20000000, then CTRL=0x05 → STATUS bit2 1→0; period 16→8 clocks with no short or double pulse at the switch.
- Coherent read: CYCLES=0x000000FF, read addr 8, let 2 edges occur, read 9..11 → bytes FF,00,00,00. Clear strobe → next read of addr 8 returns 0.
